// File: rtl/imem_line_arbiter_pkg.sv
// Shared definitions for the instruction-memory line arbiter.
//   - arb_state_e : arbiter FSM states, 2-bit encoding
//   - LINE_BYTES  : bytes per line (one memory beat per byte)
//   - ADDR_W_DEF / LINE_W_DEF : default line-address and line widths
package imem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    FILL  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  localparam int LINE_BYTES = 16;
  localparam int ADDR_W_DEF = 28;
  localparam int LINE_W_DEF = LINE_BYTES * 8;

endpackage

// File: rtl/imem_line_arbiter_rr_pick.sv
// Combinational round-robin selector.
//   req  : one request bit per requester
//   last : index of the most recently served requester
//   any  : at least one request bit is set
//   id   : first set request found scanning from last+1 with wrap-around
module rr_pick #(
  parameter int N_REQ = 2,
  parameter int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  last,
  output logic             any,
  output logic [ID_W-1:0]  id
);

  // Scan starting one past the last winner so the last winner has lowest priority.
  always_comb begin
    int idx;
    any = 1'b0;
    id  = '0;
    idx = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(last) + k) % N_REQ;
      if (!any && req[idx]) begin
        any = 1'b1;
        id  = ID_W'(idx);
      end else begin
        id  = id;
      end
    end
  end

endmodule

// File: rtl/imem_line_arbiter.sv
// Shares one byte-serial instruction memory (16 beats per line) among N_REQ
// i-cache banks. Each bank sees a bare-memory read/busywait contract; lines are
// granted round-robin and a started burst always runs to completion.
// Ports:
//   clock, reset      : clock; asynchronous active-low reset
//   req_read          : per-requester line read request (held until busywait low)
//   req_address       : packed per-requester line addresses, slice i = requester i
//   req_readdata      : registered line buffer, broadcast to all requesters
//   req_busywait      : per-requester stall
//   mem_read          : registered read strobe to the memory
//   mem_address       : registered line address to the memory
//   mem_readdata      : memory line output
//   mem_busywait      : memory stall, low on the final beat
//   grant_id          : requester currently owning the memory
//   active            : high while in BURST/FILL/RESP
module imem_line_arbiter
  import imem_arb_pkg::*;
#(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LINE_W = LINE_W_DEF,
  parameter int ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_read,
  input  logic [N_REQ*ADDR_W-1:0] req_address,
  output logic [LINE_W-1:0]       req_readdata,
  output logic [N_REQ-1:0]        req_busywait,
  output logic                    mem_read,
  output logic [ADDR_W-1:0]       mem_address,
  input  logic [LINE_W-1:0]       mem_readdata,
  input  logic                    mem_busywait,
  output logic [ID_W-1:0]         grant_id,
  output logic                    active
);

  arb_state_e        state_r, state_s;
  logic [ID_W-1:0]   last_grant_r, last_grant_s;
  logic [ID_W-1:0]   grant_id_s;
  logic              mem_read_s;
  logic [ADDR_W-1:0] mem_address_s;
  logic [LINE_W-1:0] req_readdata_s;
  logic              pick_any_s;
  logic [ID_W-1:0]   pick_id_s;
  logic [ADDR_W-1:0] addr_arr_s [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_req
    assign addr_arr_s[g] = req_address[g*ADDR_W +: ADDR_W];
    // Release only the owner, and only in its single RESP cycle.
    assign req_busywait[g] = req_read[g] &&
                             !((state_r == RESP) && (grant_id == ID_W'(g)));
  end

  rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_rr_pick (
    .req  (req_read),
    .last (last_grant_r),
    .any  (pick_any_s),
    .id   (pick_id_s)
  );

  // Next-state and next-register values for the line FSM.
  always_comb begin
    state_s        = state_r;
    last_grant_s   = last_grant_r;
    grant_id_s     = grant_id;
    mem_read_s     = mem_read;
    mem_address_s  = mem_address;
    req_readdata_s = req_readdata;
    case (state_r)
      IDLE: begin
        if (pick_any_s) begin
          state_s       = BURST;
          grant_id_s    = pick_id_s;
          mem_address_s = addr_arr_s[pick_id_s];
          mem_read_s    = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      BURST: begin
        // Memory beats cannot be cancelled, so the burst ignores req_read.
        if (!mem_busywait) begin
          state_s    = FILL;
          mem_read_s = 1'b0;
        end else begin
          state_s = BURST;
        end
      end
      FILL: begin
        req_readdata_s = mem_readdata;
        state_s        = RESP;
      end
      RESP: begin
        // Advance fairness even if the owner dropped its request mid-burst.
        last_grant_s = grant_id;
        state_s      = IDLE;
      end
      default: begin
        state_s    = IDLE;
        mem_read_s = 1'b0;
      end
    endcase
  end

  // State, grant, memory-interface and line-buffer registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r      <= IDLE;
      last_grant_r <= ID_W'(N_REQ - 1);
      grant_id     <= '0;
      mem_read     <= 1'b0;
      mem_address  <= '0;
      req_readdata <= '0;
      active       <= 1'b0;
    end else begin
      state_r      <= state_s;
      last_grant_r <= last_grant_s;
      grant_id     <= grant_id_s;
      mem_read     <= mem_read_s;
      mem_address  <= mem_address_s;
      req_readdata <= req_readdata_s;
      active       <= (state_s != IDLE);
    end
  end

endmodule

// File: tb/tb_imem_line_arbiter.sv
// Directed bench for imem_line_arbiter with a byte-serial memory model.
module tb_imem_line_arbiter;

  localparam int N_REQ  = 2;
  localparam int ADDR_W = 28;
  localparam int LINE_W = 128;
  localparam int ID_W   = 1;

  logic                    clock = 1'b0;
  logic                    reset = 1'b0;
  logic [N_REQ-1:0]        req_read = 2'b00;
  logic [ADDR_W-1:0]       addr0 = 28'h0;
  logic [ADDR_W-1:0]       addr1 = 28'h0;
  logic [N_REQ*ADDR_W-1:0] req_address;
  logic [LINE_W-1:0]       req_readdata;
  logic [N_REQ-1:0]        req_busywait;
  logic                    mem_read;
  logic [ADDR_W-1:0]       mem_address;
  logic [LINE_W-1:0]       mem_readdata;
  logic                    mem_busywait;
  logic [ID_W-1:0]         grant_id;
  logic                    active;

  int vectors     = 0;
  int miscompares = 0;

  assign req_address = {addr1, addr0};

  imem_line_arbiter #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .LINE_W(LINE_W), .ID_W(ID_W)) dut (
    .clock        (clock),
    .reset        (reset),
    .req_read     (req_read),
    .req_address  (req_address),
    .req_readdata (req_readdata),
    .req_busywait (req_busywait),
    .mem_read     (mem_read),
    .mem_address  (mem_address),
    .mem_readdata (mem_readdata),
    .mem_busywait (mem_busywait),
    .grant_id     (grant_id),
    .active       (active)
  );

  always #5 clock = ~clock;

  // Memory content: distinctive byte per (line address, byte lane).
  function automatic logic [7:0] mem_byte(input logic [ADDR_W-1:0] a, input int k);
    logic [7:0] base;
    base = {a[3:0], 4'h0} | 8'(k);
    return base ^ a[11:4];
  endfunction

  function automatic logic [LINE_W-1:0] line_of(input logic [ADDR_W-1:0] a);
    logic [LINE_W-1:0] l;
    l = '0;
    for (int k = 0; k < 16; k++) l[k*8 +: 8] = mem_byte(a, k);
    return l;
  endfunction

  // Byte-serial memory: one byte per beat, busywait low on beat 15.
  logic [3:0]        beat_r;
  logic [LINE_W-1:0] mem_line_r;
  assign mem_readdata = mem_line_r;
  assign mem_busywait = !(mem_read && (beat_r == 4'd15));

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      beat_r     <= 4'd0;
      mem_line_r <= '0;
    end else if (mem_read) begin
      mem_line_r[beat_r*8 +: 8] <= mem_byte(mem_address, int'(beat_r));
      beat_r <= beat_r + 4'd1;
    end
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset;
    req_read = 2'b00;
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    #1;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!active && !mem_read) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    req_read = 2'b11;
    tick();
    tick();
    vectors++;
    if (mem_read !== 1'b0 || active !== 1'b0 || grant_id !== 1'b0)
      begin miscompares++; $display("FAIL reset_ctrl: got rd=%b act=%b gid=%h, expected 0 0 0", mem_read, active, grant_id); end
    vectors++;
    if (mem_address !== 28'h0 || req_readdata !== 128'h0)
      begin miscompares++; $display("FAIL reset_data: got addr=%h data=%h, expected zeros", mem_address, req_readdata); end
    vectors++;
    if (req_busywait !== 2'b11)
      begin miscompares++; $display("FAIL reset_bw: got %b expected 11", req_busywait); end
    req_read = 2'b00;
    #1;
    vectors++;
    if (req_busywait !== 2'b00)
      begin miscompares++; $display("FAIL reset_bw_idle: got %b expected 00", req_busywait); end
    reset = 1'b1;
    #1;
  endtask

  task automatic test_single;
    int hi, bw_hi;
    bit ok;
    hi = 0; bw_hi = 0;
    addr0 = 28'h0000010;
    req_read = 2'b01;
    #1;
    vectors++;
    if (req_busywait !== 2'b01)
      begin miscompares++; $display("FAIL single_bw_c0: got %b expected 01", req_busywait); end
    for (int c = 1; c <= 18; c++) begin
      tick();
      if (mem_read) hi++;
      if (c <= 17 && req_busywait[0]) bw_hi++;
      if (c == 1) begin
        vectors++;
        if (mem_address !== 28'h0000010 || grant_id !== 1'b0 || active !== 1'b1)
          begin miscompares++; $display("FAIL single_c1: got addr=%h gid=%h act=%b, expected 0000010 0 1", mem_address, grant_id, active); end
      end
    end
    vectors++;
    if (hi !== 16) begin miscompares++; $display("FAIL single_rd_len: got %0d expected 16", hi); end
    vectors++;
    if (bw_hi !== 17) begin miscompares++; $display("FAIL single_bw_len: got %0d expected 17", bw_hi); end
    vectors++;
    if (req_busywait !== 2'b00)
      begin miscompares++; $display("FAIL single_bw_c18: got %b expected 00", req_busywait); end
    vectors++;
    if (req_readdata !== line_of(28'h10))
      begin miscompares++; $display("FAIL single_data: got %h expected %h", req_readdata, line_of(28'h10)); end
    tick();
    req_read = 2'b00;
    vectors++;
    if (active !== 1'b0) begin miscompares++; $display("FAIL single_c19_act: got %b expected 0", active); end
    wait_idle(ok);
  endtask

  task automatic test_contention;
    int bw1_hi;
    bit ok;
    do_reset();
    bw1_hi = 0;
    addr0 = 28'h20;
    addr1 = 28'h30;
    req_read = 2'b11;
    #1;
    if (req_busywait[1]) bw1_hi++;
    for (int c = 1; c <= 37; c++) begin
      tick();
      if (c == 19) req_read[0] = 1'b0;
      #1;
      if (c < 37 && req_busywait[1]) bw1_hi++;
      if (c == 1) begin
        vectors++;
        if (grant_id !== 1'b0 || mem_address !== 28'h20)
          begin miscompares++; $display("FAIL cont_first: got gid=%h addr=%h expected 0 0000020", grant_id, mem_address); end
      end
      if (c == 18) begin
        vectors++;
        if (req_busywait !== 2'b10 || req_readdata !== line_of(28'h20))
          begin miscompares++; $display("FAIL cont_resp0: got bw=%b data=%h expected 10 %h", req_busywait, req_readdata, line_of(28'h20)); end
      end
      if (c == 20) begin
        vectors++;
        if (grant_id !== 1'b1 || mem_address !== 28'h30)
          begin miscompares++; $display("FAIL cont_second: got gid=%h addr=%h expected 1 0000030", grant_id, mem_address); end
      end
      if (c == 37) begin
        vectors++;
        if (req_busywait[1] !== 1'b0 || req_readdata !== line_of(28'h30))
          begin miscompares++; $display("FAIL cont_resp1: got bw=%b data=%h expected bw1=0 %h", req_busywait, req_readdata, line_of(28'h30)); end
      end
    end
    vectors++;
    if (bw1_hi !== 37) begin miscompares++; $display("FAIL cont_bw1_len: got %0d expected 37", bw1_hi); end
    tick();
    req_read = 2'b00;
    wait_idle(ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL cont_idle: got busy expected idle"); end
  endtask

  task automatic test_fairness;
    int line;
    bit ok;
    logic exp_id;
    do_reset();
    addr0 = 28'h20;
    addr1 = 28'h30;
    req_read = 2'b11;
    #1;
    for (int c = 1; c <= 96; c++) begin
      tick();
      if ((c - 1) % 19 == 0) begin
        line = (c - 1) / 19;
        exp_id = (line % 2 == 1);
        vectors++;
        if (grant_id !== exp_id || mem_address !== (exp_id ? 28'h30 : 28'h20))
          begin miscompares++; $display("FAIL fair_line%0d: got gid=%h addr=%h expected gid=%h", line, grant_id, mem_address, exp_id); end
      end
    end
    req_read = 2'b00;
    wait_idle(ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL fair_idle: got busy expected idle"); end
  endtask

  task automatic test_abort;
    int hi;
    bit ok;
    do_reset();
    hi = 0;
    addr0 = 28'h40;
    addr1 = 28'h50;
    req_read = 2'b11;
    #1;
    for (int c = 1; c <= 37; c++) begin
      tick();
      if (c == 5) req_read[0] = 1'b0;
      #1;
      if (c <= 18 && mem_read) hi++;
      if (c == 18) begin
        vectors++;
        if (req_busywait !== 2'b10 || req_readdata !== line_of(28'h40))
          begin miscompares++; $display("FAIL abort_resp: got bw=%b data=%h expected 10 %h", req_busywait, req_readdata, line_of(28'h40)); end
      end
      if (c == 20) begin
        vectors++;
        if (grant_id !== 1'b1 || mem_address !== 28'h50)
          begin miscompares++; $display("FAIL abort_next: got gid=%h addr=%h expected 1 0000050", grant_id, mem_address); end
      end
      if (c == 37) begin
        vectors++;
        if (req_busywait !== 2'b00 || req_readdata !== line_of(28'h50))
          begin miscompares++; $display("FAIL abort_resp1: got bw=%b data=%h expected 00 %h", req_busywait, req_readdata, line_of(28'h50)); end
      end
    end
    vectors++;
    if (hi !== 16) begin miscompares++; $display("FAIL abort_rd_len: got %0d expected 16", hi); end
    tick();
    req_read = 2'b00;
    wait_idle(ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL abort_idle: got busy expected idle"); end
  endtask

  task automatic test_reset_mid_burst;
    int hi;
    bit ok;
    hi = 0;
    addr0 = 28'h60;
    req_read = 2'b01;
    for (int c = 1; c <= 8; c++) tick();
    vectors++;
    if (mem_read !== 1'b1) begin miscompares++; $display("FAIL rmb_pre: got rd=%b expected 1", mem_read); end
    reset = 1'b0;
    #1;
    vectors++;
    if (mem_read !== 1'b0 || active !== 1'b0 || mem_address !== 28'h0 || req_busywait !== 2'b01)
      begin miscompares++; $display("FAIL rmb_async: got rd=%b act=%b addr=%h bw=%b expected 0 0 0000000 01", mem_read, active, mem_address, req_busywait); end
    req_read = 2'b00;
    tick();
    tick();
    reset = 1'b1;
    addr0 = 28'h70;
    req_read = 2'b01;
    #1;
    for (int c = 1; c <= 18; c++) begin
      tick();
      if (mem_read) hi++;
    end
    vectors++;
    if (hi !== 16) begin miscompares++; $display("FAIL rmb_rd_len: got %0d expected 16", hi); end
    vectors++;
    if (req_busywait !== 2'b00 || req_readdata !== line_of(28'h70))
      begin miscompares++; $display("FAIL rmb_data: got bw=%b data=%h expected 00 %h", req_busywait, req_readdata, line_of(28'h70)); end
    tick();
    req_read = 2'b00;
    wait_idle(ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL rmb_idle: got busy expected idle"); end
  endtask

  task automatic test_address_hold;
    bit ok;
    addr0 = 28'h80;
    req_read = 2'b01;
    for (int c = 1; c <= 18; c++) begin
      tick();
      if (c == 3) addr0 = 28'h90;
      #1;
      if (c == 10) begin
        vectors++;
        if (mem_address !== 28'h80)
          begin miscompares++; $display("FAIL hold_addr: got %h expected 0000080", mem_address); end
      end
    end
    vectors++;
    if (req_busywait !== 2'b00 || req_readdata !== line_of(28'h80))
      begin miscompares++; $display("FAIL hold_data: got bw=%b data=%h expected 00 %h", req_busywait, req_readdata, line_of(28'h80)); end
    tick();
    req_read = 2'b00;
    wait_idle(ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL hold_idle: got busy expected idle"); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_abort();
    test_reset_mid_burst();
    test_address_hold();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
